watchdog_bank: RTL and testbench

Multi-channel successor to the single-channel IAGC watchdog. Supervises `CHANNELS` independent gate (kick) signals while the IAGC is in a selectable active status. Each channel flags a sticky fault if its gate is not seen within `TICKS` clock cycles. The block sits beside the IAGC control FSM and reports per-channel liveness, per-channel faults, an aggregate fault line and a saturating fault-event counter.

---
 rtl/watchdog_bank.sv | 129 ++++++++++++
 tb/tb_watchdog_bank.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/watchdog_bank.sv
// Per-channel gate watchdog for the IAGC: arms channels while the status is active,
// raises sticky faults on missed kicks and keeps a saturating count of expiries.
module watchdog_bank #(
  parameter int unsigned                  CHANNELS           = 4,
  parameter int unsigned                  IAGC_STATUS_SIZE   = 4,
  parameter logic [IAGC_STATUS_SIZE-1:0]  IAGC_STATUS_ACTIVE = 4'b0010,
  parameter int unsigned                  TICKS              = 10,
  parameter int unsigned                  RECOVER            = 1,
  parameter int unsigned                  FAULT_COUNT_WIDTH  = 8
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [IAGC_STATUS_SIZE-1:0]   i_iagcStatus,
  input  logic [CHANNELS-1:0]           i_enable,
  input  logic [CHANNELS-1:0]           i_gate,
  input  logic [CHANNELS-1:0]           i_clearFault,
  output logic [CHANNELS-1:0]           o_valid,
  output logic [CHANNELS-1:0]           o_fault,
  output logic                          o_anyFault,
  output logic [FAULT_COUNT_WIDTH-1:0]  o_faultCount
);

  localparam int unsigned CNT_W = $clog2(TICKS + 1);
  localparam int unsigned CW    = $clog2(CHANNELS + 1);
  localparam int unsigned SW    = FAULT_COUNT_WIDTH + CW;

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_EXPIRED  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CHANNELS-1:0][1:0]       state_q, state_d;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]            valid_q, valid_d;
  logic [CHANNELS-1:0]            fault_q, fault_d;
  logic                           any_fault_q, any_fault_d;
  logic [FAULT_COUNT_WIDTH-1:0]   fault_count_q, fault_count_d;

  logic                           status_active_c;
  logic [CHANNELS-1:0]            expire_c;
  logic [CW-1:0]                  n_expire_c;
  logic [SW-1:0]                  count_sum_c;

  // Per-channel next state: disarm has top priority, then arm / reload / expire.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    expire_c        = '0;
    status_active_c = (i_iagcStatus == IAGC_STATUS_ACTIVE);
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (!(status_active_c && i_enable[c])) begin
        state_d[c] = ST_DISARMED;
        cnt_d[c]   = '0;
      end else begin
        case (state_q[c])
          ST_DISARMED: begin
            state_d[c] = ST_ARMED;
            cnt_d[c]   = CNT_LOAD;
          end
          ST_ARMED: begin
            if (i_gate[c]) begin
              cnt_d[c] = CNT_LOAD;
            end else if (cnt_q[c] <= CNT_ONE) begin
              state_d[c]  = ST_EXPIRED;
              cnt_d[c]    = '0;
              expire_c[c] = 1'b1;
            end else begin
              cnt_d[c] = cnt_q[c] - CNT_ONE;
            end
          end
          ST_EXPIRED: begin
            if (i_gate[c] && (RECOVER != 0)) begin
              state_d[c] = ST_ARMED;
              cnt_d[c]   = CNT_LOAD;
            end
          end
          default: begin
            state_d[c] = ST_DISARMED;
            cnt_d[c]   = '0;
          end
        endcase
      end
    end
  end

  // Output next values; a fault set on the same edge as its clear wins.
  always_comb begin
    valid_d    = '0;
    n_expire_c = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      valid_d[c] = (state_d[c] == ST_ARMED);
      n_expire_c = n_expire_c + CW'(expire_c[c]);
    end
    fault_d     = expire_c | (fault_q & ~i_clearFault);
    any_fault_d = |fault_d;
    count_sum_c = SW'(fault_count_q) + SW'(n_expire_c);
    if (|count_sum_c[SW-1:FAULT_COUNT_WIDTH]) begin
      fault_count_d = '1;
    end else begin
      fault_count_d = count_sum_c[FAULT_COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= '0;
      cnt_q         <= '0;
      valid_q       <= '0;
      fault_q       <= '0;
      any_fault_q   <= 1'b0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      fault_q       <= fault_d;
      any_fault_q   <= any_fault_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_fault      = fault_q;
  assign o_anyFault   = any_fault_q;
  assign o_faultCount = fault_count_q;

endmodule

// File: tb/tb_watchdog_bank.sv
// Self-checking bench for watchdog_bank: a timestamp-based reference model feeds a
// scoreboard every cycle, plus directed checks on the key timing scenarios.
module tb_watchdog_bank;

  localparam int   TICKS   = 10;
  localparam logic [3:0] ST_IDLE = 4'b0010;
  localparam logic [3:0] ST_INIT = 4'b0001;
  localparam int   M_DIS = 0;
  localparam int   M_ARM = 1;
  localparam int   M_EXP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] status;
  logic [3:0] en, gate, clr;
  logic [3:0] o_valid, o_fault;
  logic       o_any;
  logic [7:0] o_count;
  logic [3:0] s_valid, s_fault;
  logic       s_any;
  logic [1:0] s_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] fault;
    logic       any;
    logic [7:0] count;
    logic [1:0] count2;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: expiry when TICKS edges pass since the last arm/kick.
  int         mst[4];
  int         ref_e[4];
  logic [3:0] fault_m;
  int         cnt_m, cnt2_m, edge_n;

  always #5 clk = ~clk;

  watchdog_bank #(
    .CHANNELS(4), .IAGC_STATUS_SIZE(4), .IAGC_STATUS_ACTIVE(4'b0010),
    .TICKS(TICKS), .RECOVER(1), .FAULT_COUNT_WIDTH(8)
  ) u_dut (
    .i_clock(clk), .i_reset(rst), .i_iagcStatus(status), .i_enable(en),
    .i_gate(gate), .i_clearFault(clr), .o_valid(o_valid), .o_fault(o_fault),
    .o_anyFault(o_any), .o_faultCount(o_count)
  );

  watchdog_bank #(
    .CHANNELS(4), .IAGC_STATUS_SIZE(4), .IAGC_STATUS_ACTIVE(4'b0010),
    .TICKS(TICKS), .RECOVER(1), .FAULT_COUNT_WIDTH(2)
  ) u_dut_sat (
    .i_clock(clk), .i_reset(rst), .i_iagcStatus(status), .i_enable(en),
    .i_gate(gate), .i_clearFault(clr), .o_valid(s_valid), .o_fault(s_fault),
    .o_anyFault(s_any), .o_faultCount(s_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Predict the outcome of the coming edge, push it, then advance one cycle.
  task automatic tick();
    exp_t e;
    int   ev;
    bit   act, exp_now;
    edge_n++;
    if (rst) begin
      for (int c = 0; c < 4; c++) mst[c] = M_DIS;
      fault_m = '0;
      cnt_m   = 0;
      cnt2_m  = 0;
    end else begin
      ev = 0;
      for (int c = 0; c < 4; c++) begin
        act     = (status == ST_IDLE) && en[c];
        exp_now = 1'b0;
        if (!act) begin
          mst[c] = M_DIS;
        end else if (mst[c] == M_DIS) begin
          mst[c]   = M_ARM;
          ref_e[c] = edge_n;
        end else if (mst[c] == M_ARM) begin
          if (gate[c]) ref_e[c] = edge_n;
          else if (edge_n - ref_e[c] == TICKS) begin
            mst[c]  = M_EXP;
            exp_now = 1'b1;
          end
        end else if (gate[c]) begin
          mst[c]   = M_ARM;
          ref_e[c] = edge_n;
        end
        if (exp_now) begin
          fault_m[c] = 1'b1;
          ev++;
        end else if (clr[c]) begin
          fault_m[c] = 1'b0;
        end
      end
      cnt_m  = (cnt_m + ev > 255) ? 255 : cnt_m + ev;
      cnt2_m = (cnt2_m + ev > 3) ? 3 : cnt2_m + ev;
    end
    for (int c = 0; c < 4; c++) e.valid[c] = (mst[c] == M_ARM);
    e.fault  = fault_m;
    e.any    = |fault_m;
    e.count  = 8'(cnt_m);
    e.count2 = 2'(cnt2_m);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic measure_window(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_valid[0]) n++;
      else if (n > 0) break;
    end
  endtask

  // Scoreboard: compare both instances against the prediction for each edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got no expectation, expected one per edge");
    end else begin
      e = sb_q.pop_front();
      check("sb_valid",  32'(o_valid), 32'(e.valid));
      check("sb_fault",  32'(o_fault), 32'(e.fault));
      check("sb_any",    32'(o_any),   32'(e.any));
      check("sb_count",  32'(o_count), 32'(e.count));
      check("sb_valid2", 32'(s_valid), 32'(e.valid));
      check("sb_fault2", 32'(s_fault), 32'(e.fault));
      check("sb_any2",   32'(s_any),   32'(e.any));
      check("sb_count2", 32'(s_count), 32'(e.count2));
    end
  end

  initial begin
    int n, low, fhi;
    edge_n  = 0;
    fault_m = '0;
    cnt_m   = 0;
    cnt2_m  = 0;
    for (int c = 0; c < 4; c++) begin
      mst[c]   = M_DIS;
      ref_e[c] = 0;
    end
    rst = 1'b1; status = ST_INIT; en = '0; gate = '0; clr = '0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_any",   32'(o_any),   32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    rst = 1'b0;

    // Arm and expire
    status = ST_IDLE; en = 4'b0001;
    measure_window(n);
    check("t1_window", 32'(n), 32'd10);
    check("t1_fault",  32'(o_fault), 32'h1);
    check("t1_any",    32'(o_any),   32'd1);
    check("t1_count",  32'(o_count), 32'd1);

    // Periodic kicking: period 9, then exactly at cnt==1 (period 10)
    status = ST_INIT; clr = 4'b1111;
    tick();
    clr = '0;
    check("t2_cleared", 32'(o_fault), 32'd0);
    status = ST_IDLE; low = 0; fhi = 0;
    for (int i = 0; i < 300; i++) begin
      gate[0] = (i <= 198) ? (i > 0 && i % 9 == 0) : ((i - 198) % 10 == 0);
      tick();
      if (!o_valid[0]) low++;
      if (o_fault[0]) fhi++;
    end
    gate = '0;
    check("t2_valid_low", 32'(low), 32'd0);
    check("t2_fault_hi",  32'(fhi), 32'd0);

    // Status drop mid-count, with a coincident gate
    status = ST_INIT; tick();
    status = ST_IDLE; tick();
    repeat (5) tick();
    status = ST_INIT; gate[0] = 1'b1;
    tick();
    gate = '0;
    check("t3_valid", 32'(o_valid[0]), 32'd0);
    check("t3_fault", 32'(o_fault[0]), 32'd0);
    status = ST_IDLE;
    measure_window(n);
    check("t3_window", 32'(n), 32'd10);
    check("t3_count",  32'(o_count), 32'd2);

    // Recover and clear
    gate[0] = 1'b1; tick(); gate = '0;
    check("t4_rec_valid", 32'(o_valid[0]), 32'd1);
    check("t4_rec_fault", 32'(o_fault[0]), 32'd1);
    clr[0] = 1'b1; tick(); clr = '0;
    check("t4_clr_fault", 32'(o_fault[0]), 32'd0);
    check("t4_clr_valid", 32'(o_valid[0]), 32'd1);
    status = ST_INIT; tick();
    status = ST_IDLE; tick();
    repeat (9) tick();
    clr[0] = 1'b1; tick(); clr = '0;
    check("t4_set_wins", 32'(o_fault[0]), 32'd1);
    check("t4_exp_valid", 32'(o_valid[0]), 32'd0);
    check("t4_count",    32'(o_count), 32'd3);
    tick();
    check("t4_sticky", 32'(o_fault[0]), 32'd1);
    clr[0] = 1'b1; tick(); clr = '0;
    check("t4_cleared", 32'(o_fault[0]), 32'd0);

    // Simultaneous expiry and counter saturation
    status = ST_INIT; en = 4'b1111; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_count",  32'(o_count), 32'd0);
    check("t5_rst_count2", 32'(s_count), 32'd0);
    status = ST_IDLE; tick();
    repeat (9) tick();
    check("t5_pre_fault", 32'(o_fault), 32'd0);
    check("t5_pre_count", 32'(o_count), 32'd0);
    tick();
    check("t5_fault",  32'(o_fault), 32'hf);
    check("t5_any",    32'(o_any),   32'd1);
    check("t5_count",  32'(o_count), 32'd4);
    check("t5_count2", 32'(s_count), 32'd3);
    status = ST_INIT; tick();
    status = ST_IDLE; repeat (11) tick();
    check("t5_count_b",  32'(o_count), 32'd8);
    check("t5_count2_b", 32'(s_count), 32'd3);

    // Reset mid-countdown
    status = ST_INIT; tick();
    status = ST_IDLE; repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6a_valid", 32'(o_valid), 32'd0);
    check("t6a_fault", 32'(o_fault), 32'd0);
    check("t6a_any",   32'(o_any),   32'd0);
    check("t6a_count", 32'(o_count), 32'd0);

    // Reset while expired, with gates asserted
    repeat (11) tick();
    check("t6b_pre_count", 32'(o_count), 32'd4);
    tick();
    rst = 1'b1; gate = 4'b1111; tick(); rst = 1'b0; gate = '0;
    check("t6b_valid", 32'(o_valid), 32'd0);
    check("t6b_fault", 32'(o_fault), 32'd0);
    check("t6b_any",   32'(o_any),   32'd0);
    check("t6b_count", 32'(o_count), 32'd0);

    // Reset on the expiry edge beats the counter increment
    tick();
    repeat (9) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6c_fault", 32'(o_fault), 32'd0);
    check("t6c_count", 32'(o_count), 32'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
